prf_read_arbiter: RTL and testbench
===================================

Name: prf_read_arbiter

Overview:
- Shares the physical register file's read ports among NUM_REQ issue-side requesters. Each requester needs zero, one or two source operands.
- Each cycle the block picks requesters in round-robin order and drives the PRF read-port enables and addresses. The PRF read is combinational; the block registers the read data and returns it to each granted requester one cycle later.
- It also provides starvation protection and a squash path. It sits between the reservation-station issue logic and the PRF.

Parameters:
- NUM_REQ, 4, number of requesters (at least 2).
- READ_PORTS, 4, number of PRF read ports (at least 2).
- MAX_WAIT, 3, consecutive ungranted cycles after which a requester is marked starved (at least 1).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req  input  NUM_REQ  request valid, one bit per requester
- need1  input  NUM_REQ  requester i needs its src1 operand
- need2  input  NUM_REQ  requester i needs its src2 operand
- src1_idx  input  NUM_REQ x PHYS_REG_IDX  src1 physical register index
- src2_idx  input  NUM_REQ x PHYS_REG_IDX  src2 physical register index
- squash  input  1  flush: no grants this cycle; responses are killed
- gnt  output  NUM_REQ  combinational grant this cycle
- rf_re  output  READ_PORTS  PRF read enables
- rf_raddr  output  READ_PORTS x PHYS_REG_IDX  PRF read addresses
- rf_rdata  input  READ_PORTS x DATA  PRF read data, same cycle
- resp_valid  output  NUM_REQ  registered: operands ready for requester i
- resp_src1  output  NUM_REQ x DATA  registered src1 value (0 if not needed)
- resp_src2  output  NUM_REQ x DATA  registered src2 value (0 if not needed)

Behaviour:
- Cost: cost(i) = need1[i] + need2[i], which is 0, 1 or 2 ports.
- Scan order:
  - First, every requester with req set and starved[i] set, in ascending index order.
  - Then the remaining requesters in round-robin order, starting at rr_ptr and wrapping at NUM_REQ.
- Greedy, non-blocking fill:
  - A requester is granted if req[i]=1 and cost(i) is at most the ports still free.
  - A requester that does not fit is skipped; later requesters may still be granted.
  - A requester with cost 0 is always granted when req=1 and uses no ports.
- Port assignment:
  - Ports are assigned consecutively from port 0 in scan order: src1 first, then src2.
  - A port that receives an assignment has rf_re=1 and rf_raddr set to the index.
  - An unused port has rf_re=0 and rf_raddr=0.
- Squash: when squash=1, gnt=0 and rf_re=0 in that cycle, regardless of requests.
- Round-robin pointer update:
  - rr_ptr is updated at the clock edge to (last round-robin-phase grantee + 1) mod NUM_REQ.
  - Grants made in the starved phase do not move rr_ptr.
  - If nothing was granted in the round-robin phase, rr_ptr is unchanged.
- Starvation counters:
  - wait_cnt[i] increments, saturating at MAX_WAIT, when req[i]=1 and gnt[i]=0. This includes cycles with squash=1.
  - wait_cnt[i] clears when gnt[i]=1 or req[i]=0.
  - starved[i] = (wait_cnt[i] == MAX_WAIT).
- Response stage (one cycle latency):
  - At the edge after a grant, resp_valid[i] goes to 1.
  - resp_src1 and resp_src2 are captured from the rf_rdata ports assigned to requester i. A field whose need bit is 0 captures 0.
  - An ungranted requester gets resp_valid=0. Its resp_src fields hold their previous values.
  - If squash=1, all resp_valid are cleared at the next edge. This kills any response that would have been produced.
  - Requesters must drop or update req after a grant. A request held for a second cycle is treated as a new request.
- Reset: rr_ptr, all wait_cnt, and all resp_valid/resp_src1/resp_src2 are cleared at the next edge. gnt and rf_re are 0 while reset=1. A reset asserted mid-stream discards the pending response stage.
- Invariants:
  - Granted ports never exceed READ_PORTS.
  - No port is driven by two requesters.
  - gnt[i] implies req[i].

Test Plan:
- All 4 requesters with need1=need2=1, rr_ptr=0, no squash: cycle 0 grants {0,1}, ports 0-3 carry src1_0, src2_0, src1_1, src2_1 and rr_ptr becomes 2. Cycle 1 grants {2,3} and rr_ptr becomes 0. Each resp_valid rises on the cycle after its grant, with data matching the PRF contents.
- rr_ptr=0 with costs req0=1, req1=2, req2=2, req3=1: gnt=1011b, ports hold 0:s1_0, 1:s1_1, 2:s2_1, 3:s1_3, and rr_ptr becomes 0 (past 3, wrapped). Requester 2 has wait_cnt=1.
- Cost-0 request from requester 2 alongside four costly ports already used by requesters 0 and 1: requester 2 is still granted. Next cycle resp_valid[2]=1 with resp_src1=resp_src2=0.
- Starvation: squash held for 3 cycles while req0 (cost 2) is pending, so wait_cnt[0]=3. Then squash=0, rr_ptr=2, with req2 and req3 each cost 2: grants go to {0,2}, requester 3 is skipped, and rr_ptr becomes 3.
- Squash in the grant cycle with requesters 0 and 1 requesting: gnt=0 and rf_re=0. On the next cycle resp_valid=0 and wait counters increment.
- Reset asserted the cycle after a grant: resp_valid stays 0 and rr_ptr=0. After reset deasserts, the first grant starts from requester 0.

Source files
------------

// File: rtl/prf_read_arbiter.sv
// prf_read_arbiter: round-robin PRF read-port arbiter with starvation priority, squash and registered operand return
module prf_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int READ_PORTS = 4,
    parameter int MAX_WAIT   = 3,
    parameter int IDX_W      = 6,
    parameter int DATA_W     = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0]                  need1,
    input  logic [NUM_REQ-1:0]                  need2,
    input  logic [NUM_REQ-1:0][IDX_W-1:0]       src1_idx,
    input  logic [NUM_REQ-1:0][IDX_W-1:0]       src2_idx,
    input  logic                                squash,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic [READ_PORTS-1:0]               rf_re,
    output logic [READ_PORTS-1:0][IDX_W-1:0]    rf_raddr,
    input  logic [READ_PORTS-1:0][DATA_W-1:0]   rf_rdata,
    output logic [NUM_REQ-1:0]                  resp_valid,
    output logic [NUM_REQ-1:0][DATA_W-1:0]      resp_src1,
    output logic [NUM_REQ-1:0][DATA_W-1:0]      resp_src2
);
    localparam int RW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [RW-1:0]                  rr_ptr, rr_next;
    logic [NUM_REQ-1:0][CW-1:0]     wait_cnt;
    logic [NUM_REQ-1:0]             starved;
    logic [NUM_REQ-1:0][DATA_W-1:0] d1, d2;
    always_comb begin
        int free, p, c;
        logic hit;
        gnt      = '0;
        rf_re    = '0;
        rf_raddr = '0;
        d1       = '0;
        d2       = '0;
        rr_next  = rr_ptr;
        free     = READ_PORTS;
        p        = 0;
        for (int i = 0; i < NUM_REQ; i++) starved[i] = wait_cnt[i] == CW'(MAX_WAIT);
        for (int s = 0; s < 2 * NUM_REQ; s++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hit = s < NUM_REQ ? (i == s && starved[i])
                                  : (i == (int'(rr_ptr) + s - NUM_REQ) % NUM_REQ && !starved[i]);
                c = int'(need1[i]) + int'(need2[i]);
                if (hit && req[i] && !squash && !reset && c <= free) begin
                    gnt[i] = 1'b1;
                    free   = free - c;
                    if (s >= NUM_REQ) rr_next = RW'((i + 1) % NUM_REQ);
                    for (int q = 0; q < READ_PORTS; q++) begin
                        if (need1[i] && q == p) begin
                            rf_re[q]    = 1'b1;
                            rf_raddr[q] = src1_idx[i];
                            d1[i]       = rf_rdata[q];
                        end
                        if (need2[i] && q == p + int'(need1[i])) begin
                            rf_re[q]    = 1'b1;
                            rf_raddr[q] = src2_idx[i];
                            d2[i]       = rf_rdata[q];
                        end
                    end
                    p = p + c;
                end
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr     <= '0;
            wait_cnt   <= '0;
            resp_valid <= '0;
            resp_src1  <= '0;
            resp_src2  <= '0;
        end else begin
            rr_ptr     <= rr_next;
            resp_valid <= gnt;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= (!req[i] || gnt[i]) ? '0
                             : wait_cnt[i] + CW'(wait_cnt[i] != CW'(MAX_WAIT));
                if (gnt[i]) begin
                    resp_src1[i] <= d1[i];
                    resp_src2[i] <= d2[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_prf_read_arbiter.sv
// tb_prf_read_arbiter: directed checks of grants, port mapping, starvation, squash and reset
module tb_prf_read_arbiter;
    localparam int N = 4, P = 4, IW = 6, DW = 32;
    localparam logic [DW-1:0] BASE = 32'hD000_0000;
    logic                 clock, reset, squash;
    logic [N-1:0]         req, need1, need2, gnt, resp_valid;
    logic [N-1:0][IW-1:0] src1_idx, src2_idx;
    logic [P-1:0]         rf_re;
    logic [P-1:0][IW-1:0] rf_raddr;
    logic [P-1:0][DW-1:0] rf_rdata;
    logic [N-1:0][DW-1:0] resp_src1, resp_src2;
    int tests = 0, fails = 0;

    prf_read_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .need1(need1), .need2(need2),
        .src1_idx(src1_idx), .src2_idx(src2_idx), .squash(squash), .gnt(gnt),
        .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .resp_valid(resp_valid), .resp_src1(resp_src1), .resp_src2(resp_src2)
    );

    always #5 clock = ~clock;

    always_comb
        for (int q = 0; q < P; q++) rf_rdata[q] = BASE | DW'(rf_raddr[q]);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] n1, input logic [N-1:0] n2,
                         input logic sq);
        req = r; need1 = n1; need2 = n2; squash = sq;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clock = 0; reset = 1;
        for (int i = 0; i < N; i++) begin
            src1_idx[i] = IW'(8 + i);
            src2_idx[i] = IW'(16 + i);
        end
        drive(4'hF, 4'hF, 4'hF, 0);
        check("rst_gnt", gnt, 0);
        check("rst_re", rf_re, 0);
        tick();
        check("rst_rv", resp_valid, 0);
        check("rst_src1", resp_src1, 0);
        reset = 0;
        // all four cost 2, pointer at 0
        drive(4'hF, 4'hF, 4'hF, 0);
        check("c0_gnt", gnt, 4'b0011);
        check("c0_re", rf_re, 4'hF);
        check("c0_raddr", rf_raddr, {6'd17, 6'd9, 6'd16, 6'd8});
        tick();
        check("c0_rv", resp_valid, 4'b0011);
        check("c0_r1_0", resp_src1[0], BASE | 8);
        check("c0_r2_0", resp_src2[0], BASE | 16);
        check("c0_r1_1", resp_src1[1], BASE | 9);
        check("c0_r2_1", resp_src2[1], BASE | 17);
        drive(4'b1100, 4'hF, 4'hF, 0);
        check("c1_gnt", gnt, 4'b1100);
        check("c1_raddr", rf_raddr, {6'd19, 6'd11, 6'd18, 6'd10});
        tick();
        check("c1_rv", resp_valid, 4'b1100);
        check("c1_r1_2", resp_src1[2], BASE | 10);
        check("c1_r2_3", resp_src2[3], BASE | 19);
        check("c1_hold_r1_0", resp_src1[0], BASE | 8);
        // mixed costs 1,2,2,1 from pointer 0
        drive(4'hF, 4'hF, 4'b0110, 0);
        check("mix_gnt", gnt, 4'b1011);
        check("mix_raddr", rf_raddr, {6'd11, 6'd17, 6'd9, 6'd8});
        tick();
        check("mix_rv", resp_valid, 4'b1011);
        check("mix_r2_0_zero", resp_src2[0], 0);
        check("mix_r2_1", resp_src2[1], BASE | 17);
        check("mix_r1_3", resp_src1[3], BASE | 11);
        drive(4'b0111, 4'b0111, 4'b0111, 0);
        check("mix_wrap_gnt", gnt, 4'b0011);
        tick();
        // cost-0 requester 2 with ports exhausted by 0 and 1
        drive(4'b0111, 4'b0011, 4'b0011, 0);
        check("z_gnt", gnt, 4'b0111);
        check("z_re", rf_re, 4'hF);
        tick();
        check("z_rv", resp_valid, 4'b0111);
        check("z_r1_2", resp_src1[2], 0);
        check("z_r2_2", resp_src2[2], 0);
        // starvation built under squash
        drive(4'b0001, 4'b0001, 4'b0001, 1);
        check("sq3_gnt", gnt, 0);
        check("sq3_re", rf_re, 0);
        tick();
        check("sq3_rv", resp_valid, 0);
        tick();
        tick();
        drive(4'b1101, 4'b1101, 4'b1101, 0);
        check("st_gnt", gnt, 4'b0101);
        check("st_raddr", rf_raddr, {6'd18, 6'd10, 6'd16, 6'd8});
        tick();
        check("st_rv", resp_valid, 4'b0101);
        drive(4'hF, 4'hF, 4'hF, 0);
        check("st_rr3_gnt", gnt, 4'b1001);
        tick();
        // squash in the grant cycle
        drive(4'b0011, 4'hF, 4'hF, 1);
        check("sq_gnt", gnt, 0);
        check("sq_re", rf_re, 0);
        check("sq_raddr", rf_raddr, 0);
        tick();
        check("sq_rv", resp_valid, 0);
        tick();
        tick();
        drive(4'hF, 4'hF, 4'hF, 0);
        check("sq_starved_gnt", gnt, 4'b0011);
        tick();
        drive(4'hF, 4'hF, 4'hF, 0);
        check("sq_rr_kept_gnt", gnt, 4'b0110);
        tick();
        // reset right after a grant
        drive(4'b0011, 4'hF, 4'hF, 0);
        check("rs_pre_gnt", gnt, 4'b0011);
        tick();
        check("rs_pre_rv", resp_valid, 4'b0011);
        reset = 1;
        drive(4'hF, 4'hF, 4'hF, 0);
        check("rs_gnt", gnt, 0);
        check("rs_re", rf_re, 0);
        tick();
        check("rs_rv", resp_valid, 0);
        check("rs_src2", resp_src2, 0);
        reset = 0;
        drive(4'hF, 4'hF, 4'hF, 0);
        check("rs_post_gnt", gnt, 4'b0011);
        tick();
        check("rs_post_rv", resp_valid, 4'b0011);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
